// File: rtl/pipeline_stall_controller_pkg.sv
// Shared constants for the pipeline hazard/stall sequencer.
package pipeline_stall_controller_pkg;
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         MEM_TIMEOUT_DEF = 64;
  localparam int         CNT_W_DEF       = 16;
endpackage

// File: rtl/pipeline_stall_controller_load_use_detect.sv
// Combinational load-use match between the load in EX and the sources of ID.
module load_use_detect
  import pipeline_stall_controller_pkg::*;
(
  input  logic       ex_memread_i,
  input  logic [4:0] ex_wreg_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  output logic       match_o
);
  // r0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign match_o = ex_memread_i && (ex_wreg_i != REG_ZERO) &&
                   ((ex_wreg_i == id_rs_i) || (id_uses_rt_i && (ex_wreg_i == id_rt_i)));
endmodule

// File: rtl/pipeline_stall_controller.sv
// Hazard and stall sequencer: memory freeze > taken branch > load-use,
// plus a saturating stall counter and a sticky memory-timeout flag.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_WriteReg,
  input  logic             EX_BranchTaken,
  input  logic             MEM_MemAccess,
  input  logic             MemReady,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Bubble,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Bubble,
  output logic [CNT_W-1:0] StallCount,
  output logic             MemTimeout
);
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble}
  localparam logic [6:0] CTL_RESET  = 7'b0011101;
  localparam logic [6:0] CTL_FREEZE = 7'b0000001;
  localparam logic [6:0] CTL_BRANCH = 7'b1111110;
  localparam logic [6:0] CTL_LDUSE  = 7'b0001110;
  localparam logic [6:0] CTL_NORMAL = 7'b1101010;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              to_q, to_d;
  logic              lu_match, freeze, branch, loaduse;
  logic [6:0]        ctl;

  load_use_detect u_lud (
    .ex_memread_i (EX_MemRead),
    .ex_wreg_i    (EX_WriteReg),
    .id_rs_i      (ID_rs),
    .id_rt_i      (ID_rt),
    .id_uses_rt_i (ID_UsesRt),
    .match_o      (lu_match)
  );

  always_comb begin
    freeze  = ((state_q == MEM_WAIT) || MEM_MemAccess) && !MemReady;
    branch  = !freeze && EX_BranchTaken;
    loaduse = !freeze && !branch && lu_match;

    ctl = CTL_NORMAL;
    if (Rst)          ctl = CTL_RESET;
    else if (freeze)  ctl = CTL_FREEZE;
    else if (branch)  ctl = CTL_BRANCH;
    else if (loaduse) ctl = CTL_LDUSE;

    state_d = state_q;
    case (state_q)
      RUN:      if (MEM_MemAccess && !MemReady) state_d = MEM_WAIT;
      MEM_WAIT: if (MemReady) state_d = RUN;
      default:  state_d = RUN;
    endcase

    wait_d = '0;
    if (state_d == MEM_WAIT)
      wait_d = (wait_q == WC_MAX) ? wait_q : wait_q + WC_W'(1);

    // The pipe keeps waiting after a timeout; the flag only reports it.
    to_d = to_q || ((state_d == MEM_WAIT) && (wait_d == WC_MAX));

    stall_d = stall_q;
    if (!ctl[6] && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      to_q    <= to_d;
    end
  end

  assign {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
          ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble} = ctl;
  assign StallCount = stall_q;
  assign MemTimeout = to_q;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Random + directed bench for pipeline_stall_controller against a cycle-level reference model.
module tb_pipeline_stall_controller;
  localparam int MT    = 4;
  localparam int CW    = 4;
  localparam int SMAX  = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [4:0]    ID_rs, ID_rt, EX_WriteReg;
  logic          ID_UsesRt, EX_MemRead, EX_BranchTaken, MEM_MemAccess, MemReady;
  logic          PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble;
  logic          EX_MEM_Write, MEM_WB_Bubble, MemTimeout;
  logic [CW-1:0] StallCount;

  int checks = 0;
  int errors = 0;

  // Model: is a memory access outstanding, how many consecutive frozen edges,
  // stall-cycle total and sticky timeout.
  bit m_pend;
  int m_wait, m_stall;
  bit m_to;

  pipeline_stall_controller #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg), .EX_BranchTaken(EX_BranchTaken),
    .MEM_MemAccess(MEM_MemAccess), .MemReady(MemReady),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Write(ID_EX_Write), .ID_EX_Bubble(ID_EX_Bubble), .EX_MEM_Write(EX_MEM_Write),
    .MEM_WB_Bubble(MEM_WB_Bubble), .StallCount(StallCount), .MemTimeout(MemTimeout)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_ctl(input bit frz);
    bit lu;
    lu = EX_MemRead && (EX_WriteReg != 0) &&
         ((EX_WriteReg == ID_rs) || (ID_UsesRt && (EX_WriteReg == ID_rt)));
    if (Rst)            return 7'b0011101;
    if (frz)            return 7'b0000001;
    if (EX_BranchTaken) return 7'b1111110;
    if (lu)             return 7'b0001110;
    return 7'b1101010;
  endfunction

  task automatic clr();
    Rst = 0; ID_rs = 0; ID_rt = 0; ID_UsesRt = 0; EX_MemRead = 0; EX_WriteReg = 0;
    EX_BranchTaken = 0; MEM_MemAccess = 0; MemReady = 1;
  endtask

  // Inputs are set by the caller just after a rising edge; one clock cycle passes here.
  task automatic cyc(input string tag);
    logic [6:0] e;
    bit frz;
    #2;
    frz = (m_pend || MEM_MemAccess) && !MemReady;
    e = exp_ctl(frz);
    chk({tag, ".ctl"}, {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
                        ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble}, e);
    if (Rst) begin
      m_pend = 0; m_wait = 0; m_stall = 0; m_to = 0;
    end else begin
      if (frz) begin
        if (m_wait < MT) m_wait++;
        if (m_wait == MT) m_to = 1;
      end else m_wait = 0;
      m_pend = frz;
      if (!e[6] && m_stall < SMAX) m_stall++;
    end
    @(posedge Clk);
    #1;
    chk({tag, ".stallcnt"}, StallCount, m_stall);
    chk({tag, ".timeout"}, MemTimeout, m_to);
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(3))
      0: return 5'd0;
      1: return 5'd8;
      2: return 5'd9;
      default: return 5'($urandom_range(31));
    endcase
  endfunction

  initial begin
    clr(); Rst = 1;
    cyc("reset");
    cyc("reset2");

    // load-use on rs, then the bubble leaves EX
    clr(); EX_MemRead = 1; EX_WriteReg = 8; ID_rs = 8; cyc("lu_rs");
    clr(); ID_rs = 8; cyc("lu_after");
    clr(); EX_MemRead = 1; EX_WriteReg = 0; ID_rs = 0; cyc("lu_r0");
    // rt-only match
    clr(); EX_MemRead = 1; EX_WriteReg = 9; ID_rt = 9; ID_rs = 3; cyc("rt_nouse");
    clr(); EX_MemRead = 1; EX_WriteReg = 9; ID_rt = 9; ID_rs = 3; ID_UsesRt = 1; cyc("rt_use");
    clr(); cyc("rt_after");
    // branch and load-use together
    clr(); EX_BranchTaken = 1; EX_MemRead = 1; EX_WriteReg = 8; ID_rs = 8; cyc("br_lu");
    // 3-cycle memory wait with a branch held in EX
    clr(); Rst = 1; cyc("rst_mw");
    clr(); MEM_MemAccess = 1; MemReady = 0; EX_BranchTaken = 1;
    repeat (3) cyc("memwait");
    MemReady = 1; cyc("memready");
    clr(); cyc("memdone");
    // timeout: ready held low 6 cycles
    clr(); MEM_MemAccess = 1; MemReady = 0;
    repeat (6) cyc("to_wait");
    MemReady = 1; cyc("to_ready");
    clr(); cyc("to_sticky");
    // reset mid-wait
    clr(); MEM_MemAccess = 1; MemReady = 0; cyc("rmw_enter");
    cyc("rmw_wait");
    Rst = 1; cyc("rmw_rst");
    Rst = 0; MEM_MemAccess = 0; MemReady = 0; cyc("rmw_run");

    // random traffic
    for (int i = 0; i < 600; i++) begin
      Rst            = ($urandom_range(59) == 0);
      ID_rs          = pick_reg();
      ID_rt          = pick_reg();
      ID_UsesRt      = 1'($urandom_range(1));
      EX_MemRead     = ($urandom_range(2) == 0);
      EX_WriteReg    = pick_reg();
      EX_BranchTaken = ($urandom_range(4) == 0);
      MEM_MemAccess  = ($urandom_range(2) == 0);
      MemReady       = ($urandom_range(9) < 4);
      cyc("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central hazard and stall sequencer for the 5-stage pipeline. It drives the write-enable and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB buffers. It resolves three hazard types: load-use, taken branch, and a variable-latency data memory that stalls the pipe. It also keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

Parameters:
MEM_TIMEOUT, 64, wait cycles in MEM_WAIT before MemTimeout is set (must be ≥1)
CNT_W, 16, width of StallCount

Ports:
Clk  in  1  pipeline clock; all state updates on posedge
Rst  in  1  synchronous, active-high reset
ID_rs  in  5  rs field of the instruction in ID
ID_rt  in  5  rt field of the instruction in ID
ID_UsesRt  in  1  ID instruction reads rt as a source
EX_MemRead  in  1  instruction in EX is a load
EX_WriteReg  in  5  destination register of the EX instruction
EX_BranchTaken  in  1  branch/jump in EX resolved taken
MEM_MemAccess  in  1  load or store in MEM needs data memory
MemReady  in  1  data memory completes the MEM access this cycle
PC_Write  out  1  PC load enable
IF_ID_Write  out  1  IF/ID load enable
IF_ID_Flush  out  1  IF/ID loads a NOP
ID_EX_Write  out  1  ID/EX load enable
ID_EX_Bubble  out  1  ID/EX loads a bubble (all control 0)
EX_MEM_Write  out  1  EX/MEM load enable
MEM_WB_Bubble  out  1  drives MEM/WB stall_in and NoWrite; WB gets no regWrite
StallCount  out  CNT_W  cycles in which PC_Write=0, saturating
MemTimeout  out  1  sticky: MEM_WAIT lasted ≥ MEM_TIMEOUT cycles

Behaviour:
- Single clock domain. Reset is synchronous and active-high: Rst is sampled only on posedge Clk.
- State machine has two states, RUN and MEM_WAIT. Encoding: RUN=0, MEM_WAIT=1.
- Registered state: State, WaitCnt (ceil(log2(MEM_TIMEOUT+1)) bits), StallCount, MemTimeout.
- On reset: State=RUN, WaitCnt=0, StallCount=0, MemTimeout=0.
- Control outputs while Rst=1: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Write=1, ID_EX_Bubble=1, EX_MEM_Write=0, MEM_WB_Bubble=1.
- Control outputs are combinational from State and the current inputs (zero latency). Priority is freeze > branch > load-use.
- freeze = (State==MEM_WAIT || MEM_MemAccess) && !MemReady.
  - Outputs when freeze: PC_Write=IF_ID_Write=ID_EX_Write=EX_MEM_Write=0, IF_ID_Flush=0, ID_EX_Bubble=0, MEM_WB_Bubble=1.
  - The instruction in MEM retires exactly once, in the cycle MemReady=1.
- branch = !freeze && EX_BranchTaken.
  - Outputs when branch: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Write=1, ID_EX_Bubble=1, EX_MEM_Write=1, MEM_WB_Bubble=0.
  - A load-use match in the same cycle is ignored, because the ID instruction is squashed.
- loaduse = !freeze && !branch && EX_MemRead && EX_WriteReg!=0 && (EX_WriteReg==ID_rs || (ID_UsesRt && EX_WriteReg==ID_rt)).
  - Outputs when loaduse: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, ID_EX_Write=1, EX_MEM_Write=1, MEM_WB_Bubble=0, IF_ID_Flush=0.
  - Exactly one bubble is inserted, because the load leaves EX on the next edge.
- Otherwise: all write enables are 1, and flush and both bubbles are 0.
- Branch and load-use are evaluated only on advance cycles. A branch or load sitting in EX during a freeze is acted on in the cycle the freeze releases.
- State transitions:
  - RUN→MEM_WAIT when MEM_MemAccess && !MemReady.
  - MEM_WAIT→RUN when MemReady=1. That same cycle is a normal advance cycle.
  - MemReady=1 in the first access cycle means no wait state is entered.
- WaitCnt:
  - Cleared whenever the next state is RUN.
  - Otherwise increments, saturating at MEM_TIMEOUT.
  - When WaitCnt reaches MEM_TIMEOUT, MemTimeout←1 and stays 1 until Rst. The pipe keeps waiting.
- StallCount increments by 1 on each non-reset cycle with PC_Write=0. It holds at 2^CNT_W−1.
- Reset asserted mid-wait forces RUN on the next edge regardless of MemReady.

Decomposition:
- Shared package contains:
  - state encoding constants RUN/MEM_WAIT;
  - REG_ZERO=5'd0;
  - default values for MEM_TIMEOUT and CNT_W.
- One natural sub-module, load_use_detect: purely combinational comparator producing the loaduse match from the EX/ID fields.

Test Plan:
- Load-use: EX_MemRead=1, EX_WriteReg=8, ID_rs=8 → PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 for exactly one cycle. Repeat with EX_WriteReg=0 → no stall.
- rt-only match: ID_rt=9, EX_WriteReg=9. With ID_UsesRt=0 → no stall; with ID_UsesRt=1 → one-cycle stall.
- Branch plus load-use in the same cycle → IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1; StallCount unchanged.
- Memory wait: MEM_MemAccess=1, MemReady low for 3 cycles → 3 cycles of all write enables 0 and MEM_WB_Bubble=1. On the 4th cycle (MemReady=1) all enables are 1, State=RUN, StallCount=3.
- Timeout: MEM_TIMEOUT=4, MemReady held low for 6 cycles → MemTimeout rises after the 4th MEM_WAIT edge and stays 1 after MemReady.
- Reset mid-wait: Rst pulsed in MEM_WAIT → next cycle State=RUN, StallCount=0, MemTimeout=0, reset output values as specified.
